// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types and constants
package core_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2,
      HALT = 2'd3
   } fetch_state_t;

   localparam logic [1:0]  CAUSE_NONE          = 2'd0;
   localparam logic [1:0]  CAUSE_MISALIGNED    = 2'd1;
   localparam logic [1:0]  CAUSE_RANGE         = 2'd2;

   localparam logic [31:0] NOP_WORD            = 32'h0000_0013;
   localparam logic [31:0] EBREAK_WORD_DEFAULT = 32'h0010_0073;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC priority mux with alignment and range check
module next_pc_sel
   import core_pkg::*;
#(
   parameter int IMEM_WORDS = 1024
) (
   input  logic [31:0] pc,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] next_pc,
   output logic [1:0]  fault_cause
);

   localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

   // 33-bit so that pc+4 wrapping past 2^32 still lands above the limit
   logic [32:0] next_wide;

   always_comb begin
      if (jump) begin
         next_wide = {1'b0, jump_target};
      end else if (branch_taken) begin
         next_wide = {1'b0, branch_target};
      end else begin
         next_wide = {1'b0, pc} + 33'd4;
      end

      next_pc = next_wide[31:0];

      if (next_wide[1:0] != 2'b00) begin
         fault_cause = CAUSE_MISALIGNED;
      end else if (next_wide >= PC_LIMIT) begin
         fault_cause = CAUSE_RANGE;
      end else begin
         fault_cause = CAUSE_NONE;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch stage: PC register, fetch FSM, retire counter
module pc_fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          IMEM_WORDS   = 1024,
   parameter logic [31:0] EBREAK_WORD  = EBREAK_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] imem_addr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        trap_o,
   output logic [1:0]  trap_cause_o,
   output logic        halted_o,
   output logic [31:0] instret_o
);

   fetch_state_t state, state_next;
   logic [31:0]  pc, pc_next;
   logic         trap, trap_next;
   logic [1:0]   cause, cause_next;
   logic         halted, halted_next;
   logic [31:0]  instret, instret_next;

   logic [31:0]  sel_pc;
   logic [1:0]   sel_fault;
   logic         fetch_valid;

   next_pc_sel #(
      .IMEM_WORDS (IMEM_WORDS)
   ) u_next_pc_sel (
      .pc            (pc),
      .jump          (jump_i),
      .jump_target   (jump_target_i),
      .branch_taken  (branch_taken_i),
      .branch_target (branch_target_i),
      .next_pc       (sel_pc),
      .fault_cause   (sel_fault)
   );

   assign fetch_valid = (state == RUN) && !stall_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= BOOT;
         pc      <= RESET_VECTOR;
         trap    <= 1'b0;
         cause   <= CAUSE_NONE;
         halted  <= 1'b0;
         instret <= 32'd0;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         trap    <= trap_next;
         cause   <= cause_next;
         halted  <= halted_next;
         instret <= instret_next;
      end
   end

   // EBREAK outranks a fault on the same fetch; both retire and hold the PC
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      trap_next    = trap;
      cause_next   = cause;
      halted_next  = halted;
      instret_next = instret;
      case (state)
         BOOT: state_next = RUN;
         RUN: begin
            if (!stall_i) begin
               instret_next = instret + 32'd1;
               if (imem_instr_i == EBREAK_WORD) begin
                  state_next  = HALT;
                  halted_next = 1'b1;
               end else if (sel_fault != CAUSE_NONE) begin
                  state_next = TRAP;
                  trap_next  = 1'b1;
                  cause_next = sel_fault;
               end else begin
                  pc_next = sel_pc;
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign pc_o          = pc;
   assign pc_plus4_o    = pc + 32'd4;
   assign imem_addr_o   = {2'b00, pc[31:2]};
   assign instr_valid_o = fetch_valid;
   assign instr_o       = fetch_valid ? imem_instr_i : NOP_WORD;
   assign trap_o        = trap;
   assign trap_cause_o  = cause;
   assign halted_o      = halted;
   assign instret_o     = instret;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with directed vectors
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBRK   = 32'h0010_0073;
   localparam logic [31:0] ADDI   = 32'h0010_0093;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic [31:0] branch_target_i = 32'd0;
   logic        jump_i = 1'b0;
   logic [31:0] jump_target_i = 32'd0;
   logic [31:0] imem_instr_i = 32'd0;
   logic [31:0] imem_addr_o, pc_o, pc_plus4_o, instr_o, instret_o;
   logic        instr_valid_o, trap_o, halted_o;
   logic [1:0]  trap_cause_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] plus4;
      logic        valid;
      logic [31:0] instr;
      logic        trap;
      logic [1:0]  cause;
      logic        halted;
      logic [31:0] instret;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc_no = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .RESET_VECTOR (32'h0000_0000),
      .IMEM_WORDS   (1024),
      .EBREAK_WORD  (32'h0010_0073)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .imem_instr_i    (imem_instr_i),
      .imem_addr_o     (imem_addr_o),
      .pc_o            (pc_o),
      .pc_plus4_o      (pc_plus4_o),
      .instr_o         (instr_o),
      .instr_valid_o   (instr_valid_o),
      .trap_o          (trap_o),
      .trap_cause_o    (trap_cause_o),
      .halted_o        (halted_o),
      .instret_o       (instret_o)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_no, act, req);
      end
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("pc_o",          pc_o,                   e.pc);
         check("imem_addr_o",   imem_addr_o,            e.addr);
         check("pc_plus4_o",    pc_plus4_o,             e.plus4);
         check("instr_valid_o", {31'd0, instr_valid_o}, {31'd0, e.valid});
         check("instr_o",       instr_o,                e.instr);
         check("trap_o",        {31'd0, trap_o},        {31'd0, e.trap});
         check("trap_cause_o",  {30'd0, trap_cause_o},  {30'd0, e.cause});
         check("halted_o",      {31'd0, halted_o},      {31'd0, e.halted});
         check("instret_o",     instret_o,              e.instret);
         cyc_no++;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // drive one cycle of inputs and queue the outputs expected during it
   task automatic cyc(input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic [31:0] ins,
                      input logic [31:0] epc, input logic ev, input logic et,
                      input logic [1:0] ec, input logic eh, input logic [31:0] ei);
      exp_t e;
      stall_i = st; branch_taken_i = br; branch_target_i = bt;
      jump_i = j; jump_target_i = jt; imem_instr_i = ins;
      e.pc = epc; e.addr = {2'b00, epc[31:2]}; e.plus4 = epc + 32'd4;
      e.valid = ev; e.instr = ev ? ins : NOP;
      e.trap = et; e.cause = ec; e.halted = eh; e.instret = ei;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      do_reset();
      // sequential fetch, then jump-over-branch priority, branch alone, stall with pending jump
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   1,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'h4,   1,0,0,0, 1);
      cyc(0,1,32'h40, 1,32'h80, ADDI, 32'h8,   1,0,0,0, 2);
      cyc(0,1,32'h40, 0,32'h80, ADDI, 32'h80,  1,0,0,0, 3);
      cyc(0,0,0,      1,32'h10, ADDI, 32'h40,  1,0,0,0, 4);
      cyc(1,0,0,      1,32'h100,ADDI, 32'h10,  0,0,0,0, 5);
      cyc(1,0,0,      1,32'h100,ADDI, 32'h10,  0,0,0,0, 5);
      cyc(1,0,0,      1,32'h100,ADDI, 32'h10,  0,0,0,0, 5);
      cyc(0,0,0,      1,32'h100,ADDI, 32'h10,  1,0,0,0, 5);
      cyc(0,1,32'h20, 0,0,      ADDI, 32'h100, 1,0,0,0, 6);
      // EBREAK together with a misaligned jump: halt wins
      cyc(0,0,0,      1,32'h22, EBRK, 32'h20,  1,0,0,0, 7);
      cyc(0,0,0,      0,0,      ADDI, 32'h20,  0,0,0,1, 8);
      cyc(1,1,32'h40, 1,32'h80, ADDI, 32'h20,  0,0,0,1, 8);

      do_reset();
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(0,0,0,      1,32'h22, ADDI, 32'h0,   1,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,1,1,0, 1);
      cyc(0,1,32'h40, 1,32'h80, ADDI, 32'h0,   0,1,1,0, 1);

      do_reset();
      // BOOT ignores stall; then walk to the top word and fall off it
      cyc(1,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(0,0,0,      1,32'hFF8,ADDI, 32'h0,   1,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'hFF8, 1,0,0,0, 1);
      cyc(0,0,0,      0,0,      ADDI, 32'hFFC, 1,0,0,0, 2);
      cyc(0,0,0,      0,0,      ADDI, 32'hFFC, 0,1,2,0, 3);

      do_reset();
      // misaligned and out of range at once reports misaligned
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(0,1,32'h1002,0,0,     ADDI, 32'h0,   1,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,1,1,0, 1);

      do_reset();
      // aligned branch exactly at the limit is out of range
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(0,1,32'h1000,0,0,     ADDI, 32'h0,   1,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,1,2,0, 1);

      do_reset();
      // reset while stalled in RUN
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(1,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      do_reset();
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   0,0,0,0, 0);
      cyc(0,0,0,      0,0,      ADDI, 32'h0,   1,0,0,0, 0);

      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
